// File: rtl/ctrl_decode_stage.sv
// Registered RV32I(+M) decode-stage control: ID/EX control fields, load-use interlock,
// multi-cycle MUL/DIV issue stall, flush and illegal-instruction flagging.
module ctrl_decode_stage #(
  parameter int ENABLE_M   = 0,
  parameter int ALU_W      = 5,
  parameter int MULDIV_LAT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  logic [6:0]       opcode,
  input  logic [2:0]       fun3,
  input  logic [6:0]       fun7,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic             ex_load,
  input  logic [4:0]       ex_rd,
  input  logic             flush,
  output logic             stall,
  output logic             out_valid,
  output logic             reg_write,
  output logic             load,
  output logic             store,
  output logic             branch,
  output logic             jalr_out,
  output logic             mem_en,
  output logic             next_sel,
  output logic             operand_a,
  output logic             operand_b,
  output logic [2:0]       imm_sel,
  output logic [1:0]       mem_to_reg,
  output logic [ALU_W-1:0] alu_control,
  output logic             muldiv,
  output logic             illegal
);

  localparam int CNT_W = (MULDIV_LAT > 1) ? $clog2(MULDIV_LAT) : 1;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // state | meaning
  // IDLE  | decoding normally, load-use interlock active
  // BUSY  | M op in EX, holding IF/ID until its last EX cycle
  typedef enum logic {IDLE, BUSY} state_t;

  typedef struct packed {
    logic       out_valid;
    logic       reg_write;
    logic       load;
    logic       store;
    logic       branch;
    logic       jalr_out;
    logic       mem_en;
    logic       next_sel;
    logic       operand_a;
    logic       operand_b;
    logic [2:0] imm_sel;
    logic [1:0] mem_to_reg;
    logic [4:0] alu;
    logic       muldiv;
    logic       illegal;
  } ctrl_t;

  state_t           state, nxt_state;
  logic [CNT_W-1:0] cnt, nxt_cnt;
  ctrl_t            dec, q;
  logic             uses_rs1, uses_rs2, is_m, hit, issue;

  always_comb begin
    dec           = '0;
    dec.out_valid = 1'b1;
    uses_rs1      = 1'b0;
    uses_rs2      = 1'b0;
    is_m          = 1'b0;
    case (opcode)
      OP_R: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        if (fun7 == 7'b0000001) begin
          if (ENABLE_M != 0) begin
            is_m          = 1'b1;
            dec.muldiv    = 1'b1;
            dec.reg_write = 1'b1;
            dec.alu       = {2'b10, fun3};
          end else begin
            dec.illegal = 1'b1;
          end
        end else if (fun7 == 7'b0000000 || fun7 == 7'b0100000) begin
          dec.reg_write = 1'b1;
          dec.alu       = {1'b0, fun7[5], fun3};
        end else begin
          dec.illegal = 1'b1;
        end
      end
      OP_I: begin
        uses_rs1      = 1'b1;
        dec.reg_write = 1'b1;
        dec.operand_b = 1'b1;
        // only the shift-right pair uses fun7[5] as a sub-op selector
        dec.alu       = {1'b0, (fun3 == 3'b101) ? fun7[5] : 1'b0, fun3};
      end
      OP_LOAD: begin
        uses_rs1       = 1'b1;
        dec.reg_write  = 1'b1;
        dec.load       = 1'b1;
        dec.mem_en     = 1'b1;
        dec.mem_to_reg = 2'd1;
        dec.operand_b  = 1'b1;
      end
      OP_STORE: begin
        uses_rs1      = 1'b1;
        uses_rs2      = 1'b1;
        dec.store     = 1'b1;
        dec.mem_en    = 1'b1;
        dec.imm_sel   = 3'd1;
        dec.operand_b = 1'b1;
      end
      OP_BRANCH: begin
        uses_rs1    = 1'b1;
        uses_rs2    = 1'b1;
        dec.branch  = 1'b1;
        dec.imm_sel = 3'd2;
        dec.alu     = {2'b00, fun3};
      end
      OP_JAL: begin
        dec.reg_write  = 1'b1;
        dec.next_sel   = 1'b1;
        dec.imm_sel    = 3'd4;
        dec.mem_to_reg = 2'd2;
      end
      OP_JALR: begin
        uses_rs1       = 1'b1;
        dec.reg_write  = 1'b1;
        dec.jalr_out   = 1'b1;
        dec.operand_b  = 1'b1;
        dec.mem_to_reg = 2'd2;
      end
      OP_LUI, OP_AUIPC: begin
        dec.reg_write = 1'b1;
        dec.imm_sel   = 3'd3;
        dec.operand_a = 1'b1;
        dec.operand_b = 1'b1;
      end
      default: dec.illegal = 1'b1;
    endcase
  end

  assign hit = valid & ex_load & (ex_rd != 5'd0) &
               (((ex_rd == rs1) & uses_rs1) | ((ex_rd == rs2) & uses_rs2));

  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    issue     = 1'b0;
    stall     = 1'b0;
    if (rst || flush) begin
      nxt_state = IDLE;
      nxt_cnt   = '0;
    end else if (state == BUSY) begin
      stall   = 1'b1;
      nxt_cnt = cnt - CNT_W'(1);
      if (cnt == CNT_W'(1)) nxt_state = IDLE;
    end else if (hit) begin
      stall = 1'b1;
    end else if (valid) begin
      issue = 1'b1;
      if (is_m && MULDIV_LAT > 1) begin
        nxt_state = BUSY;
        nxt_cnt   = CNT_W'(MULDIV_LAT - 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      q     <= '0;
    end else begin
      state <= nxt_state;
      cnt   <= nxt_cnt;
      q     <= issue ? dec : '0;
    end
  end

  assign out_valid   = q.out_valid;
  assign reg_write   = q.reg_write;
  assign load        = q.load;
  assign store       = q.store;
  assign branch      = q.branch;
  assign jalr_out    = q.jalr_out;
  assign mem_en      = q.mem_en;
  assign next_sel    = q.next_sel;
  assign operand_a   = q.operand_a;
  assign operand_b   = q.operand_b;
  assign imm_sel     = q.imm_sel;
  assign mem_to_reg  = q.mem_to_reg;
  assign alu_control = ALU_W'(q.alu);
  assign muldiv      = q.muldiv;
  assign illegal     = q.illegal;

endmodule

// File: tb/tb_ctrl_decode_stage.sv
// Bench for ctrl_decode_stage: M-enabled and M-disabled instances driven in lockstep,
// checked against an instruction-level reference model.
module tb_ctrl_decode_stage;
  localparam int LAT = 4;

  logic       clk = 1'b0;
  logic       rst, valid, ex_load, flush;
  logic [6:0] opcode, fun7;
  logic [2:0] fun3;
  logic [4:0] rs1, rs2, ex_rd;

  logic       stall_m, ov_m, rw_m, ld_m, st_m, br_m, jr_m, me_m, ns_m, oa_m, ob_m, md_m, il_m;
  logic [2:0] imm_m;
  logic [1:0] m2r_m;
  logic [4:0] alu_m;
  logic       stall_n, ov_n, rw_n, ld_n, st_n, br_n, jr_n, me_n, ns_n, oa_n, ob_n, md_n, il_n;
  logic [2:0] imm_n;
  logic [1:0] m2r_n;
  logic [4:0] alu_n;

  int n_cmp = 0;
  int n_err = 0;
  int busy_m = 0;
  int busy_n = 0;

  always #5 clk = ~clk;

  ctrl_decode_stage #(.ENABLE_M(1), .ALU_W(5), .MULDIV_LAT(LAT)) dut_m (
    .clk(clk), .rst(rst), .valid(valid), .opcode(opcode), .fun3(fun3), .fun7(fun7),
    .rs1(rs1), .rs2(rs2), .ex_load(ex_load), .ex_rd(ex_rd), .flush(flush),
    .stall(stall_m), .out_valid(ov_m), .reg_write(rw_m), .load(ld_m), .store(st_m),
    .branch(br_m), .jalr_out(jr_m), .mem_en(me_m), .next_sel(ns_m), .operand_a(oa_m),
    .operand_b(ob_m), .imm_sel(imm_m), .mem_to_reg(m2r_m), .alu_control(alu_m),
    .muldiv(md_m), .illegal(il_m));

  ctrl_decode_stage #(.ENABLE_M(0), .ALU_W(5), .MULDIV_LAT(LAT)) dut_n (
    .clk(clk), .rst(rst), .valid(valid), .opcode(opcode), .fun3(fun3), .fun7(fun7),
    .rs1(rs1), .rs2(rs2), .ex_load(ex_load), .ex_rd(ex_rd), .flush(flush),
    .stall(stall_n), .out_valid(ov_n), .reg_write(rw_n), .load(ld_n), .store(st_n),
    .branch(br_n), .jalr_out(jr_n), .mem_en(me_n), .next_sel(ns_n), .operand_a(oa_n),
    .operand_b(ob_n), .imm_sel(imm_n), .mem_to_reg(m2r_n), .alu_control(alu_n),
    .muldiv(md_n), .illegal(il_n));

  wire [21:0] obs_m = {ov_m, rw_m, ld_m, st_m, br_m, jr_m, me_m, ns_m, oa_m, ob_m,
                       imm_m, m2r_m, alu_m, md_m, il_m};
  wire [21:0] obs_n = {ov_n, rw_n, ld_n, st_n, br_n, jr_n, me_n, ns_n, oa_n, ob_n,
                       imm_n, m2r_n, alu_n, md_n, il_n};

  // Returns {uses_rs1, uses_rs2, starts_muldiv, control word in obs_* order}.
  function automatic logic [24:0] ref_decode(input logic [6:0] op, input logic [2:0] f3,
                                             input logic [6:0] f7, input bit en_m);
    logic u1, u2, mul, rw, ld, st, br, jr, me, ns, oa, ob, md, il;
    logic [2:0] imm;
    logic [1:0] m2r;
    logic [4:0] alu;
    {u1, u2, mul, rw, ld, st, br, jr, me, ns, oa, ob, md, il} = '0;
    imm = 3'd0; m2r = 2'd0; alu = 5'd0;
    case (op)
      7'b0110011: begin
        u1 = 1; u2 = 1;
        if (f7 == 7'd1) begin
          if (en_m) begin mul = 1; md = 1; rw = 1; alu = 5'd16 + 5'(f3); end
          else il = 1;
        end else if (f7 == 7'd0 || f7 == 7'd32) begin
          rw = 1; alu = (f7 == 7'd32 ? 5'd8 : 5'd0) + 5'(f3);
        end else il = 1;
      end
      7'b0010011: begin
        u1 = 1; rw = 1; ob = 1;
        alu = ((f3 == 3'd5 && f7[5]) ? 5'd8 : 5'd0) + 5'(f3);
      end
      7'b0000011: begin u1 = 1; rw = 1; ld = 1; me = 1; m2r = 2'd1; ob = 1; end
      7'b0100011: begin u1 = 1; u2 = 1; st = 1; me = 1; imm = 3'd1; ob = 1; end
      7'b1100011: begin u1 = 1; u2 = 1; br = 1; imm = 3'd2; alu = 5'(f3); end
      7'b1101111: begin rw = 1; ns = 1; imm = 3'd4; m2r = 2'd2; end
      7'b1100111: begin u1 = 1; rw = 1; jr = 1; ob = 1; m2r = 2'd2; end
      7'b0110111, 7'b0010111: begin rw = 1; imm = 3'd3; oa = 1; ob = 1; end
      default: il = 1;
    endcase
    return {u1, u2, mul, 1'b1, rw, ld, st, br, jr, me, ns, oa, ob, imm, m2r, alu, md, il};
  endfunction

  // Expected stall this cycle and control word after the coming edge; advances busy count.
  task automatic model(input bit en_m, inout int busy, output logic exp_stall,
                       output logic [21:0] exp_out);
    logic [24:0] d;
    logic hit;
    d = ref_decode(opcode, fun3, fun7, en_m);
    hit = valid && ex_load && ex_rd != 0 &&
          ((ex_rd == rs1 && d[24]) || (ex_rd == rs2 && d[23]));
    exp_stall = 1'b0;
    exp_out = '0;
    if (rst || flush) busy = 0;
    else if (busy > 0) begin exp_stall = 1'b1; busy--; end
    else if (hit) exp_stall = 1'b1;
    else if (valid) begin
      exp_out = d[21:0];
      if (d[22]) busy = LAT - 1;
    end
  endtask

  task automatic chk(input string tag, input logic [21:0] obs, input logic [21:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs are set after a falling edge; stall checked before the rise, outputs after it.
  task automatic tick();
    logic sm, sn;
    logic [21:0] em, en;
    #1;
    model(1'b1, busy_m, sm, em);
    model(1'b0, busy_n, sn, en);
    chk("stall_m", 22'(stall_m), 22'(sm));
    chk("stall_n", 22'(stall_n), 22'(sn));
    @(posedge clk); #1;
    chk("ctrl_m", obs_m, em);
    chk("ctrl_n", obs_n, en);
    @(negedge clk);
  endtask

  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                           input logic [4:0] a, input logic [4:0] b);
    valid = 1; opcode = op; fun3 = f3; fun7 = f7; rs1 = a; rs2 = b;
  endtask

  task automatic expect_bit(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  logic [6:0] op_tab [10] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                              7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1111111};
  logic [6:0] f7_tab [4] = '{7'b0000000, 7'b0100000, 7'b0000001, 7'b0000000};

  initial begin
    int stalls;
    rst = 1; valid = 0; opcode = 0; fun3 = 0; fun7 = 0; rs1 = 0; rs2 = 0;
    ex_load = 0; ex_rd = 0; flush = 0;
    @(negedge clk);
    tick(); tick();
    rst = 0;

    // add x3,x1,x2
    set_instr(7'b0110011, 3'd0, 7'd0, 5'd1, 5'd2);
    tick();
    expect_bit("add_reg_write", rw_m, 1'b1);
    expect_bit("add_alu_zero", alu_m == 5'b00000, 1'b1);
    expect_bit("add_out_valid", ov_m, 1'b1);

    // lw x5 in EX, add x6,x5,x2 in ID
    ex_load = 1; ex_rd = 5'd5;
    set_instr(7'b0110011, 3'd0, 7'd0, 5'd5, 5'd2);
    tick();
    expect_bit("lu_bubble", ov_m, 1'b0);
    ex_load = 0;
    tick();
    expect_bit("lu_issue", ov_m, 1'b1);
    ex_load = 1; ex_rd = 5'd0;
    set_instr(7'b0110011, 3'd0, 7'd0, 5'd0, 5'd2);
    tick();
    ex_load = 0;

    // mul x7,x1,x2 then an add waiting behind it
    set_instr(7'b0110011, 3'd0, 7'd1, 5'd1, 5'd2);
    tick();
    expect_bit("mul_muldiv", md_m, 1'b1);
    expect_bit("mul_alu", alu_m == 5'b10000, 1'b1);
    expect_bit("mul_illegal_noM", il_n, 1'b1);
    expect_bit("mul_rw_noM", rw_n, 1'b0);
    set_instr(7'b0110011, 3'd0, 7'd0, 5'd3, 5'd4);
    stalls = 0;
    for (int i = 0; i < 4; i++) begin
      #1 if (stall_m) stalls++;
      #0 tick();
    end
    expect_bit("mul_stall_cycles", stalls == 3, 1'b1);

    // flush in the 2nd BUSY cycle
    set_instr(7'b0110011, 3'd4, 7'd1, 5'd1, 5'd2);
    tick();
    set_instr(7'b0110011, 3'd0, 7'd0, 5'd3, 5'd4);
    tick();
    flush = 1;
    tick();
    flush = 0;
    tick();

    // unknown opcode
    set_instr(7'b1111111, 3'd0, 7'd0, 5'd1, 5'd2);
    tick();
    expect_bit("illegal_flag", il_m, 1'b1);
    expect_bit("illegal_mem_en", me_m, 1'b0);

    // reset during BUSY
    set_instr(7'b0110011, 3'd6, 7'd1, 5'd1, 5'd2);
    tick();
    set_instr(7'b0110011, 3'd0, 7'd0, 5'd3, 5'd4);
    tick();
    rst = 1;
    tick();
    rst = 0;
    tick();
    tick();

    for (int i = 0; i < 3000; i++) begin
      valid   = ($urandom_range(0, 9) != 0);
      opcode  = op_tab[$urandom_range(0, 9)];
      if ($urandom_range(0, 19) == 0) opcode = 7'($urandom);
      fun3    = 3'($urandom);
      fun7    = f7_tab[$urandom_range(0, 3)];
      if ($urandom_range(0, 15) == 0) fun7 = 7'($urandom);
      rs1     = 5'($urandom_range(0, 3));
      rs2     = 5'($urandom_range(0, 3));
      ex_load = 1'($urandom);
      ex_rd   = 5'($urandom_range(0, 3));
      flush   = ($urandom_range(0, 19) == 0);
      rst     = ($urandom_range(0, 99) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
